z80_bus_bridge: RTL and testbench



---
 rtl/z80_bus_bridge.sv | 154 +++++++++++++++
 tb/tb_z80_bus_bridge.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/z80_bus_bridge.sv
// Z80 memory-bus bridge to Port A of the GPU RAM data mux.
// Turns asynchronous Z80 strobes into single-clock read/write commands.
module z80_bus_bridge #(
    parameter int          SYNC_STAGES = 2,
    parameter logic [1:0]  WINDOW_SEL  = 2'b01,
    parameter int          TIMEOUT     = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [21:0] z80_addr,
    input  logic        z80_mreq_n,
    input  logic        z80_rd_n,
    input  logic        z80_wr_n,
    input  logic [7:0]  z80_data_in,
    output logic [7:0]  z80_data_out,
    output logic        z80_data_oe,
    output logic        z80_wait_n,
    output logic        wr_ena,
    output logic        rd_req,
    output logic [19:0] address,
    output logic [7:0]  data_out,
    input  logic        gpu_rd_rdy,
    input  logic [7:0]  gpu_data_in,
    output logic        rd_timeout
);

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        RD_HOLD,
        WR_HOLD
    } state_t;

    state_t state, state_n;

    logic [SYNC_STAGES-1:0] mreq_q, rd_q, wr_q;
    logic                   mreq_s, rd_s, wr_s;
    logic                   hit, armed;
    logic [7:0]             cnt, cnt_n;

    logic        rd_req_n, wr_ena_n, rd_timeout_n;
    logic        oe_n, wait_n_n;
    logic [7:0]  z_dout_n, data_out_n;
    logic [19:0] address_n;

    // Synchronisers clear to "active" so a reset never arms on stale ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            mreq_q <= '0;
            rd_q   <= '0;
            wr_q   <= '0;
        end else begin
            mreq_q <= {mreq_q[SYNC_STAGES-2:0], z80_mreq_n};
            rd_q   <= {rd_q[SYNC_STAGES-2:0], z80_rd_n};
            wr_q   <= {wr_q[SYNC_STAGES-2:0], z80_wr_n};
        end
    end

    assign mreq_s = mreq_q[SYNC_STAGES-1];
    assign rd_s   = rd_q[SYNC_STAGES-1];
    assign wr_s   = wr_q[SYNC_STAGES-1];
    assign hit    = !mreq_s && (z80_addr[21:20] == WINDOW_SEL);

    always_ff @(posedge clk) begin
        if (reset)
            armed <= 1'b0;
        else if (mreq_s && rd_s && wr_s)
            armed <= 1'b1;
    end

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        rd_req_n     = 1'b0;
        wr_ena_n     = 1'b0;
        rd_timeout_n = 1'b0;
        address_n    = address;
        data_out_n   = data_out;
        z_dout_n     = z80_data_out;
        oe_n         = z80_data_oe;
        wait_n_n     = z80_wait_n;
        unique case (state)
            IDLE: begin
                if (armed && hit && !rd_s && wr_s) begin
                    rd_req_n  = 1'b1;
                    address_n = z80_addr[19:0];
                    wait_n_n  = 1'b0;
                    cnt_n     = 8'd0;
                    state_n   = RD_WAIT;
                end else if (armed && hit && !wr_s && rd_s) begin
                    wr_ena_n   = 1'b1;
                    address_n  = z80_addr[19:0];
                    data_out_n = z80_data_in;
                    state_n    = WR_HOLD;
                end
            end
            RD_WAIT: begin
                // Data beats a coincident timeout.
                if (gpu_rd_rdy) begin
                    z_dout_n = gpu_data_in;
                    oe_n     = 1'b1;
                    wait_n_n = 1'b1;
                    state_n  = RD_HOLD;
                end else if (cnt == 8'(TIMEOUT - 1)) begin
                    z_dout_n     = 8'hFF;
                    oe_n         = 1'b1;
                    wait_n_n     = 1'b1;
                    rd_timeout_n = 1'b1;
                    state_n      = RD_HOLD;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            RD_HOLD: begin
                if (rd_s || mreq_s) begin
                    oe_n    = 1'b0;
                    state_n = IDLE;
                end
            end
            WR_HOLD: begin
                if (wr_s || mreq_s)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= 8'd0;
            rd_req       <= 1'b0;
            wr_ena       <= 1'b0;
            rd_timeout   <= 1'b0;
            address      <= 20'd0;
            data_out     <= 8'd0;
            z80_data_out <= 8'd0;
            z80_data_oe  <= 1'b0;
            z80_wait_n   <= 1'b1;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            rd_req       <= rd_req_n;
            wr_ena       <= wr_ena_n;
            rd_timeout   <= rd_timeout_n;
            address      <= address_n;
            data_out     <= data_out_n;
            z80_data_out <= z_dout_n;
            z80_data_oe  <= oe_n;
            z80_wait_n   <= wait_n_n;
        end
    end

endmodule

// File: tb/tb_z80_bus_bridge.sv
// Directed bench for z80_bus_bridge: read, write, timeout,
// non-hit, illegal strobes and reset during a read.
module tb_z80_bus_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic [21:0] z80_addr;
    logic        z80_mreq_n, z80_rd_n, z80_wr_n;
    logic [7:0]  z80_data_in;
    logic [7:0]  z80_data_out;
    logic        z80_data_oe, z80_wait_n;
    logic        wr_ena, rd_req;
    logic [19:0] address;
    logic [7:0]  data_out;
    logic        gpu_rd_rdy;
    logic [7:0]  gpu_data_in;
    logic        rd_timeout;

    int errors = 0;
    int checks = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    int to_cnt = 0;
    int both_cnt = 0;
    int n;
    logic wlow;

    z80_bus_bridge dut (
        .clk          (clk),
        .reset        (reset),
        .z80_addr     (z80_addr),
        .z80_mreq_n   (z80_mreq_n),
        .z80_rd_n     (z80_rd_n),
        .z80_wr_n     (z80_wr_n),
        .z80_data_in  (z80_data_in),
        .z80_data_out (z80_data_out),
        .z80_data_oe  (z80_data_oe),
        .z80_wait_n   (z80_wait_n),
        .wr_ena       (wr_ena),
        .rd_req       (rd_req),
        .address      (address),
        .data_out     (data_out),
        .gpu_rd_rdy   (gpu_rd_rdy),
        .gpu_data_in  (gpu_data_in),
        .rd_timeout   (rd_timeout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rd_req) rd_cnt++;
        if (wr_ena) wr_cnt++;
        if (rd_timeout) to_cnt++;
        if (rd_req && wr_ena) both_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle(input int k);
        z80_mreq_n = 1'b1;
        z80_rd_n   = 1'b1;
        z80_wr_n   = 1'b1;
        repeat (k) tick();
    endtask

    task automatic start_rd(input logic [21:0] a);
        z80_addr   = a;
        z80_mreq_n = 1'b0;
        z80_rd_n   = 1'b0;
    endtask

    task automatic wait_req(output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!rd_req && cyc < 20);
    endtask

    initial begin
        reset       = 1'b1;
        z80_addr    = 22'd0;
        z80_mreq_n  = 1'b1;
        z80_rd_n    = 1'b1;
        z80_wr_n    = 1'b1;
        z80_data_in = 8'd0;
        gpu_rd_rdy  = 1'b0;
        gpu_data_in = 8'd0;
        tick();
        tick();
        chk("rst_wr_ena", wr_ena, 0);
        chk("rst_rd_req", rd_req, 0);
        chk("rst_addr", address, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_z_dout", z80_data_out, 0);
        chk("rst_oe", z80_data_oe, 0);
        chk("rst_wait_n", z80_wait_n, 1);
        chk("rst_timeout", rd_timeout, 0);
        reset = 1'b0;
        idle(5);

        // Read with data returned three clocks after rd_req
        start_rd(22'h112345);
        wait_req(n);
        chk("rd_latency", n, 3);
        chk("rd_addr", address, 20'h12345);
        chk("rd_wait_low", z80_wait_n, 0);
        tick();
        chk("rd_req_pulse", rd_req, 0);
        tick();
        gpu_rd_rdy  = 1'b1;
        gpu_data_in = 8'hA5;
        chk("rd_wait_held", z80_wait_n, 0);
        tick();
        gpu_rd_rdy  = 1'b0;
        gpu_data_in = 8'h00;
        chk("rd_wait_rel", z80_wait_n, 1);
        chk("rd_data", z80_data_out, 8'hA5);
        chk("rd_oe", z80_data_oe, 1);
        repeat (3) tick();
        chk("rd_oe_hold", z80_data_oe, 1);
        z80_rd_n   = 1'b1;
        z80_mreq_n = 1'b1;
        tick();
        tick();
        chk("rd_oe_before", z80_data_oe, 1);
        tick();
        chk("rd_oe_drop", z80_data_oe, 0);
        chk("rd_req_count", rd_cnt, 1);
        idle(5);

        // Write held for ten clocks
        z80_addr    = 22'h1FFFFF;
        z80_data_in = 8'h3C;
        z80_mreq_n  = 1'b0;
        z80_wr_n    = 1'b0;
        wlow = 1'b0;
        repeat (10) begin
            tick();
            if (!z80_wait_n) wlow = 1'b1;
        end
        idle(5);
        chk("wr_count", wr_cnt, 1);
        chk("wr_addr", address, 20'hFFFFF);
        chk("wr_data", data_out, 8'h3C);
        chk("wr_wait_never_low", wlow, 0);
        chk("wr_no_rd", rd_cnt, 1);

        // Read that times out, then a late gpu_rd_rdy
        start_rd(22'h100010);
        wait_req(n);
        chk("to_latency", n, 3);
        n = 0;
        do begin
            tick();
            n++;
        end while (!z80_wait_n && n < 40);
        chk("to_clocks", n, 15);
        chk("to_data", z80_data_out, 8'hFF);
        chk("to_oe", z80_data_oe, 1);
        chk("to_pulse", rd_timeout, 1);
        tick();
        gpu_rd_rdy  = 1'b1;
        gpu_data_in = 8'h5A;
        tick();
        gpu_rd_rdy  = 1'b0;
        tick();
        chk("late_rdy_data", z80_data_out, 8'hFF);
        chk("late_rdy_wait", z80_wait_n, 1);
        chk("to_count", to_cnt, 1);
        idle(5);
        chk("to_oe_off", z80_data_oe, 0);

        // Access outside the window
        start_rd(22'h212345);
        wlow = 1'b0;
        repeat (8) begin
            tick();
            if (!z80_wait_n) wlow = 1'b1;
        end
        idle(5);
        chk("nohit_rd", rd_cnt, 2);
        chk("nohit_wait", wlow, 0);

        // RD and WR both low inside the window
        start_rd(22'h112345);
        z80_wr_n = 1'b0;
        wlow = 1'b0;
        repeat (8) begin
            tick();
            if (!z80_wait_n) wlow = 1'b1;
        end
        idle(5);
        chk("illegal_rd", rd_cnt, 2);
        chk("illegal_wr", wr_cnt, 1);
        chk("illegal_wait", wlow, 0);

        // Reset while waiting on the mux
        start_rd(22'h154321);
        wait_req(n);
        chk("mid_latency", n, 3);
        tick();
        tick();
        chk("mid_wait_low", z80_wait_n, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_wait_rel", z80_wait_n, 1);
        chk("mid_oe_off", z80_data_oe, 0);
        wlow = 1'b0;
        repeat (8) begin
            tick();
            if (!z80_wait_n) wlow = 1'b1;
        end
        chk("mid_no_replay", rd_cnt, 3);
        chk("mid_wait_stays", wlow, 0);
        idle(5);

        // Normal read after recovery
        start_rd(22'h1ABCDE);
        wait_req(n);
        chk("post_latency", n, 3);
        chk("post_addr", address, 20'hABCDE);
        gpu_rd_rdy  = 1'b1;
        gpu_data_in = 8'h42;
        tick();
        gpu_rd_rdy  = 1'b0;
        chk("post_data", z80_data_out, 8'h42);
        chk("post_wait", z80_wait_n, 1);
        idle(5);
        chk("post_rd_count", rd_cnt, 4);
        chk("post_oe_off", z80_data_oe, 0);
        chk("never_both", both_cnt, 0);
        chk("final_to_count", to_cnt, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
